// File: rtl/bcd_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_scanner
// Purpose  : Time-multiplexed BCD digit scanner feeding a 7-segment decoder,
//            with blank gaps, leading-zero blanking and frame-synced updates.
// Revision : 1.0
// ============================================================================
module bcd_digit_scanner #(
   parameter int NUM_DIGITS     = 4,
   parameter int CLKS_PER_DIGIT = 1000,
   parameter int BLANK_CLKS     = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lz_en,
   output logic [3:0]              bcd_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    seg_blank,
   output logic                    frame_tick,
   output logic                    bcd_err
);

   localparam int CNT_W = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_DIGIT - 1);
   localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]        r_cnt;
   logic [IDX_W-1:0]        r_idx;
   logic [4*NUM_DIGITS-1:0] r_pend_bcd;
   logic [NUM_DIGITS-1:0]   r_pend_dp;
   logic                    r_pend_vld;
   logic [4*NUM_DIGITS-1:0] r_act_bcd;
   logic [NUM_DIGITS-1:0]   r_act_dp;
   logic                    r_err;

   logic                    w_cnt_last;
   logic                    w_wrap;
   logic [3:0]              w_nib;
   logic                    w_dp;
   logic                    w_quiet_run;
   logic                    w_invalid;
   logic                    w_lz_blank;
   logic                    w_suppress;
   logic                    w_blank_ph;
   logic [NUM_DIGITS-1:0]   w_onehot;

   assign w_cnt_last = (r_cnt == C_CNT_LAST);
   assign w_wrap     = w_cnt_last && (r_idx == C_IDX_LAST);

   // Slot counter and digit index; both wrap by compare, not by rollover.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (w_cnt_last) begin
         r_cnt <= '0;
         r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Wrap consumes the old pending image before a coincident load refills it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_bcd <= '0;
         r_pend_dp  <= '0;
         r_pend_vld <= 1'b0;
         r_act_bcd  <= '0;
         r_act_dp   <= '0;
      end else begin
         if (w_wrap && r_pend_vld) begin
            r_act_bcd  <= r_pend_bcd;
            r_act_dp   <= r_pend_dp;
            r_pend_vld <= 1'b0;
         end
         if (load) begin
            r_pend_bcd <= bcd_in;
            r_pend_dp  <= dp_in;
            r_pend_vld <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_invalid) begin
         r_err <= 1'b1;
      end
   end

   always_comb begin
      w_nib = '0;
      w_dp  = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_nib = r_act_bcd[4*k +: 4];
            w_dp  = r_act_dp[k];
         end
      end
   end

   // w_quiet_run: every digit from the current one upward is zero with no dp.
   always_comb begin : lz_scan
      logic v_quiet;
      v_quiet     = 1'b1;
      w_quiet_run = 1'b0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         v_quiet = v_quiet && (r_act_bcd[4*k +: 4] == 4'd0) && !r_act_dp[k];
         if (r_idx == IDX_W'(k)) begin
            w_quiet_run = v_quiet;
         end
      end
   end

   assign w_invalid  = (w_nib > 4'd9);
   assign w_lz_blank = lz_en && (r_idx != '0) && w_quiet_run;
   assign w_suppress = w_invalid || w_lz_blank;

   generate
      if (BLANK_CLKS > 0) begin : g_blank
         assign w_blank_ph = (r_cnt < CNT_W'(BLANK_CLKS));
      end else begin : g_no_blank
         assign w_blank_ph = 1'b0;
      end
   endgenerate

   assign w_onehot = NUM_DIGITS'(1) << r_idx;

   assign digit_en   = (w_suppress || w_blank_ph) ? '0 : w_onehot;
   assign seg_blank  = w_suppress || w_blank_ph;
   assign bcd_out    = w_suppress ? 4'd0 : w_nib;
   assign dp_out     = w_suppress ? 1'b0 : w_dp;
   assign frame_tick = (r_cnt == '0) && (r_idx == '0);
   assign bcd_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_digit_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_digit_scanner
// Purpose  : Directed + randomized bench for bcd_digit_scanner against a
//            cycle-count based behavioural model.
// Revision : 1.0
// ============================================================================
module tb_bcd_digit_scanner;

   localparam int ND  = 4;
   localparam int CPD = 8;
   localparam int BLK = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load = 1'b0;
   logic [15:0]   bcd_in = '0;
   logic [3:0]    dp_in = '0;
   logic          lz_en = 1'b0;
   logic [3:0]    bcd_out;
   logic          dp_out;
   logic [3:0]    digit_en;
   logic          seg_blank;
   logic          frame_tick;
   logic          bcd_err;

   int tests = 0;
   int fails = 0;

   // Model: time since reset plus active/pending digit arrays.
   int         m_t;
   int         m_act [ND];
   bit         m_adp [ND];
   int         m_pend [ND];
   bit         m_pdp [ND];
   bit         m_pvld;
   bit         m_err;

   bcd_digit_scanner #(
      .NUM_DIGITS(ND), .CLKS_PER_DIGIT(CPD), .BLANK_CLKS(BLK)
   ) dut (
      .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
      .lz_en(lz_en), .bcd_out(bcd_out), .dp_out(dp_out), .digit_en(digit_en),
      .seg_blank(seg_blank), .frame_tick(frame_tick), .bcd_err(bcd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, m_t, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_t = 0;
      m_pvld = 0;
      m_err = 0;
      for (int j = 0; j < ND; j++) begin
         m_act[j] = 0; m_adp[j] = 0; m_pend[j] = 0; m_pdp[j] = 0;
      end
   endtask

   function automatic bit suppressed(input int i, input bit lz);
      bit quiet;
      if (m_act[i] > 9) return 1'b1;
      if (!lz || i == 0) return 1'b0;
      quiet = 1'b1;
      for (int j = i; j < ND; j++)
         if (m_act[j] != 0 || m_adp[j]) quiet = 1'b0;
      return quiet;
   endfunction

   task automatic check_outputs();
      int  c, i;
      bit  sup, blank;
      c     = m_t % CPD;
      i     = (m_t / CPD) % ND;
      sup   = suppressed(i, lz_en);
      blank = sup || (c < BLK);
      chk("frame_tick", 32'(frame_tick), 32'(c == 0 && i == 0));
      chk("digit_en",   32'(digit_en),   blank ? 32'd0 : (32'd1 << i));
      chk("seg_blank",  32'(seg_blank),  32'(blank));
      chk("bcd_out",    32'(bcd_out),    sup ? 32'd0 : 32'(m_act[i]));
      chk("dp_out",     32'(dp_out),     sup ? 32'd0 : 32'(m_adp[i]));
      chk("bcd_err",    32'(bcd_err),    32'(m_err));
   endtask

   // Called at a falling edge: drive, check, clock, advance model.
   task automatic step(input bit ld, input logic [15:0] b, input logic [3:0] d, input bit lz);
      int  c, i;
      load = ld; bcd_in = b; dp_in = d; lz_en = lz;
      #1;
      check_outputs();
      c = m_t % CPD;
      i = (m_t / CPD) % ND;
      @(posedge clk);
      if (m_act[i] > 9) m_err = 1'b1;
      if (c == CPD - 1 && i == ND - 1 && m_pvld) begin
         for (int j = 0; j < ND; j++) begin
            m_act[j] = m_pend[j]; m_adp[j] = m_pdp[j];
         end
         m_pvld = 1'b0;
      end
      if (ld) begin
         for (int j = 0; j < ND; j++) begin
            m_pend[j] = int'(b[4*j +: 4]); m_pdp[j] = d[j];
         end
         m_pvld = 1'b1;
      end
      m_t++;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic idle(input int n, input bit lz);
      for (int k = 0; k < n; k++) step(1'b0, '0, '0, lz);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_digit_en",   32'(digit_en),   32'd0);
      chk("rst_seg_blank",  32'(seg_blank),  32'd1);
      chk("rst_bcd_out",    32'(bcd_out),    32'd0);
      chk("rst_dp_out",     32'(dp_out),     32'd0);
      chk("rst_frame_tick", 32'(frame_tick), 32'd1);
      chk("rst_bcd_err",    32'(bcd_err),    32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      for (int j = 0; j < ND; j++)
         w[4*j +: 4] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(9));
      return w;
   endfunction

   initial begin
      model_reset();
      @(negedge clk);
      do_reset();

      // Idle frame, then 1234 loaded at cycle 5 shows from cycle 32.
      idle(5, 1'b0);
      step(1'b1, 16'h1234, 4'b0000, 1'b0);
      idle(64 - 6, 1'b0);

      // Leading-zero blanking with and without a decimal point.
      step(1'b1, 16'h0070, 4'b0000, 1'b1);
      while (m_t % 32 != 0) step(1'b0, '0, '0, 1'b1);
      idle(32, 1'b1);
      step(1'b1, 16'h0005, 4'b0100, 1'b1);
      while (m_t % 32 != 0) step(1'b0, '0, '0, 1'b1);
      idle(32, 1'b1);
      idle(32, 1'b0);

      // Invalid digit raises sticky error.
      step(1'b1, 16'h00A3, 4'b0000, 1'b0);
      while (m_t % 32 != 0) step(1'b0, '0, '0, 1'b0);
      step(1'b1, 16'h0000, 4'b0000, 1'b0);
      idle(70, 1'b1);
      do_reset();

      // Load exactly on the wrap cycle while an older pend is valid.
      idle(10, 1'b0);
      step(1'b1, 16'h1111, 4'b0000, 1'b0);
      while (m_t % 32 != 31) step(1'b0, '0, '0, 1'b0);
      step(1'b1, 16'h9999, 4'b0000, 1'b0);
      idle(70 - m_t, 1'b0);
      do_reset();
      idle(40, 1'b1);

      // Randomized traffic: live lz_en, sparse loads, occasional dp.
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(24) == 0)
            step(1'b1, rand_word(), ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'd0,
                 ($urandom_range(7) != 0));
         else
            step(1'b0, 16'($urandom), 4'($urandom), ($urandom_range(7) != 0));
      end

      // Random invalid digits, including a mid-slot reset afterwards.
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(30) == 0)
            step(1'b1, 16'($urandom), 4'($urandom), 1'b1);
         else
            step(1'b0, '0, '0, 1'b1);
      end
      idle(3, 1'b0);
      do_reset();
      idle(40, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout t=%0d observed=running expected=finished", m_t);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
